// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the memory-mapped UART transmitter.
//   tx_state_e       serialiser FSM states
//   REG_DATA/CTRL    values of reg_sel (addr[2])
//   ST_*             status word bit positions (reg_sel = REG_DATA reads)
//   CTL_*            control word bit positions (reg_sel = REG_CTRL writes)
//   sat4()           saturate a count to the 4-bit status field
package uart_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_e;

    localparam logic REG_DATA = 1'b0;
    localparam logic REG_CTRL = 1'b1;

    localparam int ST_BUSY      = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_FULL      = 2;
    localparam int ST_OVF       = 3;
    localparam int ST_IRQEN     = 4;
    localparam int ST_COUNT_LSB = 8;

    localparam int CTL_OVF_CLR = 0;
    localparam int CTL_IRQ_EN  = 1;

    function automatic logic [3:0] sat4(input logic [31:0] v);
        return (v > 32'd15) ? 4'hf : v[3:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, registered count, no bypass.
//   clk, rst     clock, asynchronous active-high reset (pointers/count only)
//   push_i       write request; accepted when not full, or when popping in the same cycle
//   pop_i        read request; ignored when empty
//   wr_data_i    data to push
//   rd_data_o    head entry (valid while !empty_o)
//   full_o       DEPTH entries held
//   empty_o      no entries held
//   count_o      number of entries held
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    // A push into a full FIFO is still taken when the head leaves in the same cycle.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Storage is not reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_dev_io.sv
// uart_tx_dev_io: memory-mapped 8N1 UART transmitter with TX FIFO.
//   clk             CPU clock
//   rst             asynchronous active-high reset
//   GPIOd0000000_we write strobe for this address region
//   reg_sel         0 = data/status, 1 = control/divisor
//   data_in         CPU store data
//   data_out        combinational read data for the peripheral read mux
//   tx              serial line, registered, idle high
//   busy            frame in progress
//   irq_tx_empty    level interrupt: enabled, FIFO empty and line idle
//
// state   | meaning
// S_IDLE  | line high, waiting for a queued byte
// S_START | start bit (low) for DIV cycles
// S_DATA  | eight data bits, LSB first, DIV cycles each
// S_STOP  | stop bit (high); chains straight into the next byte if one is queued
module uart_tx_dev_io
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 10000000,
    parameter int BAUD        = 115200,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        GPIOd0000000_we,
    input  logic        reg_sel,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        tx,
    output logic        busy,
    output logic        irq_tx_empty
);
    localparam int DIV   = CLK_FREQ_HZ / BAUD;
    localparam int CNT_W = $clog2(DIV);
    localparam int FCW   = $clog2(FIFO_DEPTH) + 1;

    tx_state_e        state_q;
    logic [CNT_W-1:0] baud_cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             tx_q;
    logic             busy_q;
    logic             ovf_q;
    logic             irq_en_q;
    logic             irq_q;

    logic             wr_data;
    logic             wr_ctrl;
    logic             baud_last;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_rd;
    logic [FCW-1:0]   fifo_count;
    logic [31:0]      status;
    logic             unused_data;

    assign unused_data = ^data_in[31:8];

    assign wr_data   = GPIOd0000000_we & (reg_sel == REG_DATA);
    assign wr_ctrl   = GPIOd0000000_we & (reg_sel == REG_CTRL);
    assign baud_last = (baud_cnt_q == CNT_W'(DIV - 1));

    // Pop in IDLE, or on the last stop-bit cycle so the next start bit follows with no gap.
    assign fifo_pop = ~fifo_empty &
                      ((state_q == S_IDLE) | ((state_q == S_STOP) & baud_last));

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (wr_data),
        .pop_i     (fifo_pop),
        .wr_data_i (data_in[7:0]),
        .rd_data_o (fifo_rd),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    // tx and busy are registered from the state, so both lag the FSM by one cycle
    // and stay aligned with each other.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            tx_q   <= (state_q == S_START) ? 1'b0 :
                      (state_q == S_DATA)  ? shift_q[0] : 1'b1;
            busy_q <= (state_q != S_IDLE);
            case (state_q)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        shift_q    <= fifo_rd;
                        baud_cnt_q <= '0;
                        state_q    <= S_START;
                    end
                end
                S_START: begin
                    if (baud_last) begin
                        baud_cnt_q <= '0;
                        bit_idx_q  <= '0;
                        state_q    <= S_DATA;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (baud_last) begin
                        baud_cnt_q <= '0;
                        shift_q    <= shift_q >> 1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= S_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (baud_last) begin
                        baud_cnt_q <= '0;
                        if (!fifo_empty) begin
                            shift_q <= fifo_rd;
                            state_q <= S_START;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q    <= 1'b0;
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            // A push that coincides with a pop is accepted, so it never overflows.
            if (wr_ctrl && data_in[CTL_OVF_CLR]) begin
                ovf_q <= 1'b0;
            end else if (wr_data && fifo_full && !fifo_pop) begin
                ovf_q <= 1'b1;
            end
            if (wr_ctrl) begin
                irq_en_q <= data_in[CTL_IRQ_EN];
            end
            irq_q <= irq_en_q & fifo_empty & ~busy_q;
        end
    end

    always_comb begin
        status                           = '0;
        status[ST_BUSY]                  = busy_q;
        status[ST_EMPTY]                 = fifo_empty;
        status[ST_FULL]                  = fifo_full;
        status[ST_OVF]                   = ovf_q;
        status[ST_IRQEN]                 = irq_en_q;
        status[ST_COUNT_LSB +: 4]        = sat4(32'(fifo_count));
    end

    assign data_out     = (reg_sel == REG_CTRL) ? 32'(DIV) : status;
    assign tx           = tx_q;
    assign busy         = busy_q;
    assign irq_tx_empty = irq_q;

endmodule

// File: tb/tb_uart_tx_dev_io.sv
module tb_uart_tx_dev_io;
    localparam int DIV   = 4;
    localparam int FD    = 8;
    localparam int FRAME = 10 * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic        reg_sel = 1'b0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        tx;
    logic        busy;
    logic        irq;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    uart_tx_dev_io #(
        .CLK_FREQ_HZ (4),
        .BAUD        (1),
        .FIFO_DEPTH  (FD)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .GPIOd0000000_we (we),
        .reg_sel         (reg_sel),
        .data_in         (data_in),
        .data_out        (data_out),
        .tx              (tx),
        .busy            (busy),
        .irq_tx_empty    (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s at cycle %0d: actual=%h required=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        failures++;
        if (failures <= 40) $display("FAIL %s at cycle %0d", nm, cyc);
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_q[$];
    logic [7:0] exp_rx[$];
    logic [7:0] rx_log[$];
    bit         m_active = 0;
    int         m_pos = 0;
    logic [7:0] m_byte = '0;
    bit         m_ovf = 0;
    bit         m_irq_en = 0;
    bit         e_tx = 1;
    bit         e_busy = 0;
    bit         e_irq = 0;

    // Line level at position pos (0 .. FRAME-1) of an 8N1 frame carrying b.
    function automatic bit line_bit(input logic [7:0] b, input int pos);
        if (pos < DIV) return 1'b0;
        if (pos < 9 * DIV) return b[pos / DIV - 1];
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_dout();
        int c;
        c = m_q.size();
        if (reg_sel) return 32'd4;
        return {20'h0, 4'(c > 15 ? 15 : c), 3'b0, m_irq_en, m_ovf, c == FD, c == 0, e_busy};
    endfunction

    task automatic model_step();
        bit wr_d, wr_c, full, pop, nirq;
        if (rst) begin
            m_q.delete();
            exp_rx.delete();
            m_active = 0; m_pos = 0; m_ovf = 0; m_irq_en = 0;
            e_tx = 1; e_busy = 0; e_irq = 0;
        end else begin
            wr_d = we && !reg_sel;
            wr_c = we && reg_sel;
            full = (m_q.size() == FD);
            pop  = (m_q.size() > 0) && (!m_active || m_pos == FRAME - 1);
            nirq = m_irq_en && (m_q.size() == 0) && !e_busy;
            e_tx   = m_active ? line_bit(m_byte, m_pos) : 1'b1;
            e_busy = m_active;
            e_irq  = nirq;
            if (wr_c && data_in[0]) m_ovf = 0;
            else if (wr_d && full && !pop) m_ovf = 1;
            if (wr_c) m_irq_en = data_in[1];
            if (pop) begin
                m_byte = m_q.pop_front();
                exp_rx.push_back(m_byte);
            end
            if (wr_d && (!full || pop)) m_q.push_back(data_in[7:0]);
            if (pop) begin
                m_active = 1; m_pos = 0;
            end else if (m_active) begin
                if (m_pos == FRAME - 1) m_active = 0;
                else m_pos++;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Per-cycle compare against the model.
    initial forever begin
        @(negedge clk);
        chk("tx", tx, e_tx);
        chk("busy", busy, e_busy);
        chk("irq", irq, e_irq);
        chk("data_out", data_out, exp_dout());
    end

    // Line receiver: decodes frames off tx by mid-bit sampling.
    bit         rx_on = 0;
    bit         prev_tx = 1;
    int         rx_s = 0;
    int         rx_off = 0;
    int         rx_idx = 0;
    logic [7:0] rx_sh = '0;

    initial forever begin
        @(negedge clk or posedge rst);
        if (rst) begin
            rx_on = 0;
            prev_tx = 1;
        end else begin
            if (rx_on) begin
                rx_off = cyc - rx_s;
                if (rx_off == DIV / 2) begin
                    chk("rx_start", tx, 0);
                end else if (rx_off >= DIV + DIV / 2 && (rx_off - DIV / 2) % DIV == 0) begin
                    rx_idx = (rx_off - DIV / 2) / DIV - 1;
                    if (rx_idx < 8) begin
                        rx_sh[rx_idx] = tx;
                    end else begin
                        chk("rx_stop", tx, 1);
                        rx_on = 0;
                        rx_log.push_back(rx_sh);
                        if (exp_rx.size() == 0) fail_now("rx_unexpected_byte");
                        else chk("rx_byte", rx_sh, exp_rx.pop_front());
                    end
                end
            end else if (prev_tx && !tx) begin
                rx_on = 1;
                rx_s = cyc;
            end
            prev_tx = tx;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic sel, input logic [31:0] d);
        we = 1'b1;
        reg_sel = sel;
        data_in = d;
        tick();
        we = 1'b0;
    endtask

    task automatic goto_cyc(input int c);
        @(negedge clk);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        reg_sel = 1'b0;
        repeat (3) @(negedge clk);
        n = 0;
        while (!(busy === 1'b0 && data_out[1] === 1'b1) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) fail_now("idle_timeout");
    endtask

    initial begin
        int e;
        int n;
        logic [7:0] exp_ovf [9];
        exp_ovf = '{8'hEE, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};

        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_tx", tx, 1);
        chk("reset_busy", busy, 0);
        chk("reset_irq", irq, 0);
        chk("reset_status", data_out, 32'h0000_0002);
        reg_sel = 1'b1;
        #1;
        chk("divisor_read", data_out, 32'd4);
        reg_sel = 1'b0;

        // Single byte 0x55 with junk in the ignored upper bits.
        wr(1'b0, 32'hABCD_EF55);
        e = cyc;
        goto_cyc(e + 1);  chk("sb_tx_c1", tx, 1); chk("sb_busy_c1", busy, 0);
        goto_cyc(e + 2);  chk("sb_tx_c2", tx, 0); chk("sb_busy_c2", busy, 1);
        goto_cyc(e + 5);  chk("sb_tx_c5", tx, 0);
        goto_cyc(e + 6);  chk("sb_tx_c6", tx, 1);
        goto_cyc(e + 10); chk("sb_tx_c10", tx, 0);
        goto_cyc(e + 38); chk("sb_tx_c38", tx, 1);
        goto_cyc(e + 41); chk("sb_busy_c41", busy, 1);
        goto_cyc(e + 42); chk("sb_busy_c42", busy, 0);
        wait_idle();

        // Back-to-back frames.
        wr(1'b0, 32'hA5);
        e = cyc;
        wr(1'b0, 32'h3C);
        goto_cyc(e + 41); chk("b2b_stop_tx", tx, 1);
        goto_cyc(e + 42); chk("b2b_start_tx", tx, 0); chk("b2b_busy", busy, 1);
        wait_idle();

        // Overflow while a frame is in progress.
        rx_log.delete();
        wr(1'b0, 32'hEE);
        e = cyc;
        goto_cyc(e + 10);
        for (int i = 0; i < 9; i++) wr(1'b0, 32'(i));
        goto_cyc(cyc);
        chk("ovf_status", data_out, 32'h0000_080D);
        wr(1'b1, 32'h1);
        reg_sel = 1'b0;
        goto_cyc(cyc);
        chk("ovf_cleared", data_out, 32'h0000_0805);
        wait_idle();
        chk("ovf_rx_count", rx_log.size(), 9);
        for (int i = 0; i < 9 && i < rx_log.size(); i++) chk("ovf_rx_order", rx_log[i], exp_ovf[i]);

        // Interrupt.
        wr(1'b1, 32'h2);
        wr(1'b0, 32'h81);
        e = cyc;
        goto_cyc(e + 10); chk("irq_in_frame", irq, 0);
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail_now("irq_busy_timeout");
        chk("irq_at_busy_fall", irq, 0);
        @(negedge clk);
        chk("irq_after_busy_fall", irq, 1);
        wr(1'b1, 32'h0);
        e = cyc;
        goto_cyc(e);     chk("irq_disable_same", irq, 1);
        goto_cyc(e + 1); chk("irq_disable_next", irq, 0);
        reg_sel = 1'b0;

        // Reset in the middle of a frame.
        rx_log.delete();
        wr(1'b0, 32'hFF);
        e = cyc;
        wr(1'b0, 32'h11);
        wr(1'b0, 32'h22);
        goto_cyc(e + 18);
        chk("pre_reset_status", data_out, 32'h0000_0201);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_status", data_out, 32'h0000_0002);
        tick();
        tick();
        rst = 1'b0;
        goto_cyc(cyc);
        chk("post_reset_status", data_out, 32'h0000_0002);
        goto_cyc(cyc + 100);
        chk("post_reset_no_frames", rx_log.size(), 0);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            n = $urandom_range(0, 199);
            if (n < 8) begin
                wr(1'b0, $urandom);
            end else if (n < 10) begin
                wr(1'b1, $urandom & 32'h3);
            end else if (n == 10) begin
                for (int k = 0; k < 10; k++) wr(1'b0, $urandom);
            end else begin
                reg_sel = 1'($urandom_range(0, 1));
                tick();
            end
        end
        wait_idle();
        goto_cyc(cyc + 5);
        chk("all_bytes_received", exp_rx.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
